serial_out_port: RTL
====================

SERIAL_OUT_PORT -- requirements
Module: serial_out_port

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 4, clock cycles per serial bit time; legal range 2..255.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 clr  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 L  input  1  load request; accepted only when Ready=1.
REQ-005 In_Bus  input  8  parallel byte from the output register; captured on an accepted load.
REQ-006 Serial_Out  output  1  serial line, idle high.
REQ-007 Ready  output  1  high when a new byte can be accepted.
REQ-008 Done  output  1  one-cycle pulse at the end of each completed frame.

Function
REQ-009 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); 10 bit times per frame.
REQ-010 Each bit SHALL be held on Serial_Out for exactly CLKS_PER_BIT consecutive cycles.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-012 IDLE: Serial_Out=1, Ready=1; on rising edge with L=1, In_Bus SHALL be captured into an 8-bit shift register and the state SHALL become START.
REQ-013 Ready SHALL equal (state==IDLE), combinationally; L while Ready=0 SHALL be ignored, with no effect on the frame in progress.
REQ-014 START: Serial_Out=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-015 DATA: Serial_Out = shift register bit 0; at each bit-time end, shift right one place and increment the 3-bit bit index; after bit index 7 completes, go to STOP.
REQ-016 STOP: Serial_Out=1 for CLKS_PER_BIT cycles; Done SHALL be 1 during the last cycle of STOP only; next edge returns to IDLE.
REQ-017 Latency: first start-bit cycle SHALL be the cycle after the load edge; Done SHALL be high in cycle 10*CLKS_PER_BIT counted from the first start-bit cycle as cycle 1.
REQ-018 Back-to-back: minimum gap between frames SHALL be one IDLE cycle (stop bit, then 1 idle-high cycle, then next start bit when L held high).
REQ-019 The bit-time counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, SHALL count 0..CLKS_PER_BIT-1, and SHALL wrap to 0 at each bit boundary and on entry to START.
REQ-020 The captured byte SHALL NOT change if In_Bus changes during a frame.
REQ-021 Simultaneous clr=1 and L=1: clr SHALL win; no byte is captured.

Reset
REQ-022 On a clk edge with clr=1: state=IDLE, Serial_Out=1, Ready=1, Done=0, shift register=8'h00, bit index=0, bit-time counter=0.
REQ-023 clr asserted mid-frame SHALL abort the frame; Serial_Out SHALL be 1 from the next cycle, and no Done pulse is produced for the aborted frame.
REQ-024 Outputs before the first clr edge are undefined; the bench SHALL apply clr for at least one edge.

Structure
REQ-025 State encodings (2-bit) and the frame length constant (10) SHALL live in a shared include file used by serial_out_port and its bench.
REQ-026 One sub-module, bit_timer (parameter CLKS_PER_BIT, inputs clk, clr, restart; output tick at the last cycle of each bit time), SHALL generate bit-time boundaries.
REQ-027 All outputs except Ready SHALL be registered.

Verification (CLKS_PER_BIT=4)
REQ-028 clr=1 one edge, then idle -> Serial_Out=1, Ready=1, Done=0 for all following idle cycles.
REQ-029 Load In_Bus=8'h0A -> Serial_Out bit sequence 0,0,1,0,1,0,0,0,0,1, each held 4 cycles; Done high in cycle 40 only; Ready=0 for cycles 1-40.
REQ-030 Load 8'hA5, then pulse L with In_Bus=8'hFF during DATA -> transmitted data remain 1,0,1,0,0,1,0,1; no second frame starts.
REQ-031 L held high with In_Bus=8'h00, then 8'hFF -> two frames separated by exactly one idle-high cycle; two Done pulses 41 cycles apart.
REQ-032 clr asserted in cycle 15 of a frame carrying 8'h3C -> Serial_Out=1 and Ready=1 from cycle 16; no Done pulse; next load of 8'h01 produces a correct full frame.
REQ-033 clr=1 and L=1 on the same edge with In_Bus=8'h55 -> state stays IDLE; no frame emitted.

Source files
------------

// File: rtl/serial_out_port_pkg.sv
// Shared definitions for the serial output port and its bench.
// Holds the 2-bit FSM state encoding and the frame length constant.
// No logic; constants and types only.
package serial_out_port_pkg;

  // One start bit, eight data bits, one stop bit.
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_out_port_bit_timer.sv
// Bit-time counter: marks the last cycle (tick) and second-to-last cycle (pre_tick) of each bit.
// Latency: tick is combinational from the registered count; count restarts the cycle after restart.
// Backpressure: none; free-running while restart is low.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] r_cnt;

  // Count 0..CLKS_PER_BIT-1, wrapping at each bit boundary; held at zero while restart is high.
  always_ff @(posedge clk) begin
    if (clr || restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick     = (r_cnt == LAST);
  // Lets the parent register its end-of-frame pulse one cycle ahead.
  assign pre_tick = (r_cnt == PRE);

endmodule

// File: rtl/serial_out_port.sv
// Serialises a byte as start(0), 8 data bits LSB first, stop(1); each bit held CLKS_PER_BIT cycles.
// Latency: start bit begins the cycle after the load edge; Done in the last cycle of the stop bit.
// Backpressure: Ready high only in IDLE; L while busy is ignored.
module serial_out_port
  import serial_out_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       L,
  input  logic [7:0] In_Bus,
  output logic       Serial_Out,
  output logic       Ready,
  output logic       Done
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_shreg;
  logic [7:0] w_shreg_nxt;
  logic [2:0] r_bit_idx;
  logic [2:0] w_bit_idx_nxt;
  logic       r_serial;
  logic       r_done;
  logic       w_serial_nxt;
  logic       w_done_nxt;
  logic       w_tick;
  logic       w_pre_tick;
  logic       w_timer_restart;

  // Holding the timer at zero through IDLE makes it start fresh on entry to START.
  assign w_timer_restart = (r_state == ST_IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .clr     (clr),
    .restart (w_timer_restart),
    .tick    (w_tick),
    .pre_tick(w_pre_tick)
  );

  // Next-state, next shift register and next registered outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_idx_nxt = r_bit_idx;
    unique case (r_state)
      ST_IDLE: begin
        if (L) begin
          w_shreg_nxt   = In_Bus;
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shreg_nxt   = {1'b0, r_shreg[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Serial_Out is registered, so it is computed from where the FSM is about to be.
    unique case (w_state_nxt)
      ST_START: w_serial_nxt = 1'b0;
      ST_DATA:  w_serial_nxt = w_shreg_nxt[0];
      default:  w_serial_nxt = 1'b1;
    endcase

    // Raised one cycle early so the registered Done lands on the final stop-bit cycle.
    w_done_nxt = (r_state == ST_STOP) && w_pre_tick;
  end

  // State and registered outputs; clr dominates any load on the same edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= ST_IDLE;
      r_shreg   <= 8'h00;
      r_bit_idx <= 3'd0;
      r_serial  <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_serial  <= w_serial_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign Serial_Out = r_serial;
  assign Done       = r_done;
  assign Ready      = (r_state == ST_IDLE);

endmodule
